// File: rtl/sliding_puzzle_ctrl_if.sv
// Bundles the game-sequencing inputs and the board/status outputs of the puzzle engine.
// The master side is the board-select and game logic; the slave side is the engine.
interface sliding_puzzle_ctrl_if #(
    parameter int ROWS = 2,
    parameter int COLS = 2,
    parameter int TW   = 3,
    parameter int MCW  = 10
);
    localparam int N  = ROWS * COLS;
    localparam int PW = $clog2(N);

    logic [1:0]      game_status;
    logic [3:0]      act;
    logic            active;
    logic            restart;
    logic [N*TW-1:0] origin_board;

    logic [N*TW-1:0] out;
    logic [PW-1:0]   blank_pos;
    logic [MCW-1:0]  move_cnt;
    logic            illegal;
    logic            board_err;
    logic            win_flag;

    modport master (
        output game_status, act, active, restart, origin_board,
        input  out, blank_pos, move_cnt, illegal, board_err, win_flag
    );

    modport slave (
        input  game_status, act, active, restart, origin_board,
        output out, blank_pos, move_cnt, illegal, board_err, win_flag
    );
endinterface

// File: rtl/sliding_puzzle_ctrl.sv
// Sliding-tile puzzle engine for a ROWS x COLS board.
// Holds the live board and a captured copy, applies one blank move per strobe,
// counts legal moves, and flags rejected moves, blank-less boards and the solved state.
module sliding_puzzle_ctrl #(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int TW    = 3,
    parameter int BLANK = 4,
    parameter int MCW   = 10
) (
    input logic             clk_d,
    input logic             reset,
    sliding_puzzle_ctrl_if.slave bus
);
    localparam int N         = ROWS * COLS;
    localparam int PW        = $clog2(N);
    localparam int RESET_POS = (ROWS - 1) * COLS;

    typedef enum logic [1:0] {
        CHOSE_BOARD  = 2'b00,
        GAMING       = 2'b01,
        GAME_INITIAL = 2'b10,
        WINNED       = 2'b11
    } status_e;

    status_e         status;
    logic [TW-1:0]   board_q  [N];
    logic [TW-1:0]   shadow_q [N];
    logic [TW-1:0]   origin_cell [N];
    logic [PW-1:0]   blank_q;
    logic [MCW-1:0]  cnt_q;
    logic            illegal_q;
    logic            err_q;
    logic            win_q;

    logic            load_found;
    logic [PW-1:0]   load_pos;
    logic [PW:0]     blank_cnt;
    logic            all_ordered;
    logic            win_next;
    logic            do_capture;
    logic            do_load;
    logic            do_move;
    logic [PW-1:0]   blank_row;
    logic [PW-1:0]   blank_col;
    logic            move_ok;
    logic [PW-1:0]   nb_pos;

    assign status = status_e'(bus.game_status);

    // Cell k lives at out[(N-1-k)*TW +: TW], so cell 0 occupies the MSBs.
    for (genvar k = 0; k < N; k++) begin : g_cells
        assign bus.out[(N-1-k)*TW +: TW] = board_q[k];
        assign origin_cell[k]            = bus.origin_board[(N-1-k)*TW +: TW];
    end

    assign bus.blank_pos = blank_q;
    assign bus.move_cnt  = cnt_q;
    assign bus.illegal   = illegal_q;
    assign bus.board_err = err_q;
    assign bus.win_flag  = win_q;

    // Locate the lowest-index blank in the captured board; fall back to bottom-left.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        load_found = 1'b0;
        load_pos   = PW'(RESET_POS);
        for (int k = N - 1; k >= 0; k--) begin
            if (shadow_q[k] == TW'(BLANK)) begin
                load_found = 1'b1;
                load_pos   = PW'(k);
            end
        end
    end

    // Solved when exactly one cell is blank and every other cell k holds k.
    always_comb begin
        blank_cnt   = '0;
        all_ordered = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (board_q[k] == TW'(BLANK)) begin
                blank_cnt = blank_cnt + 1'b1;
            end else if (board_q[k] != TW'(k)) begin
                all_ordered = 1'b0;
            end
        end
        win_next = all_ordered && (blank_cnt == (PW+1)'(1));
    end

    // Decide what this cycle does: capture, load (GAME_INITIAL or restart) or move.
    always_comb begin
        do_capture = (status == CHOSE_BOARD);
        do_load    = (status == GAME_INITIAL) || ((status == GAMING) && bus.restart);
        do_move    = (status == GAMING) && !bus.restart && bus.active
                     && !err_q && !win_q && (bus.act != 4'b0000);
    end

    // Pick the direction (lowest set act bit) and check the neighbour is on the board.
    always_comb begin
        blank_row = blank_q / PW'(COLS);
        blank_col = blank_q % PW'(COLS);
        move_ok   = 1'b0;
        nb_pos    = blank_q;
        if (bus.act[0]) begin
            move_ok = (blank_row != '0);
            nb_pos  = blank_q - PW'(COLS);
        end else if (bus.act[1]) begin
            move_ok = (blank_col < PW'(COLS - 1));
            nb_pos  = blank_q + PW'(1);
        end else if (bus.act[2]) begin
            move_ok = (blank_row < PW'(ROWS - 1));
            nb_pos  = blank_q + PW'(COLS);
        end else if (bus.act[3]) begin
            move_ok = (blank_col != '0);
            nb_pos  = blank_q - PW'(1);
        end
    end

    // Board, shadow, counters and flags; synchronous active-low reset wins over everything.
    always_ff @(posedge clk_d) begin
        if (!reset) begin
            // NOTE: the board and shadow are tiny register files with defined reset contents, so they are reset like any other state.
            for (int k = 0; k < N; k++) begin
                board_q[k]  <= TW'(BLANK);
                shadow_q[k] <= '0;
            end
            blank_q   <= PW'(RESET_POS);
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
            win_q     <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            win_q     <= win_next;
            if (do_capture) begin
                for (int k = 0; k < N; k++) begin
                    shadow_q[k] <= origin_cell[k];
                end
            end
            if (do_load) begin
                for (int k = 0; k < N; k++) begin
                    board_q[k] <= shadow_q[k];
                end
                cnt_q   <= '0;
                blank_q <= load_pos;
                err_q   <= !load_found;
            end else if (do_move) begin
                if (move_ok) begin
                    // NOTE: non-blocking assignments read pre-edge values, so the two cells swap without a temporary.
                    board_q[blank_q] <= board_q[nb_pos];
                    board_q[nb_pos]  <= board_q[blank_q];
                    blank_q          <= nb_pos;
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + MCW'(1);
                    end
                end else begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sliding_puzzle_ctrl.sv
// Bench for sliding_puzzle_ctrl: directed scenarios on a 2x2 and a 3x3 instance,
// then randomized traffic on the 2x2 instance against a row/column reference model.
module tb_sliding_puzzle_ctrl;
    logic clk_d = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_d = ~clk_d;

    sliding_puzzle_ctrl_if #(.ROWS(2), .COLS(2), .TW(3), .MCW(10)) b2 ();
    sliding_puzzle_ctrl_if #(.ROWS(3), .COLS(3), .TW(4), .MCW(2))  b3 ();

    sliding_puzzle_ctrl #(.ROWS(2), .COLS(2), .TW(3), .BLANK(4), .MCW(10)) dut2 (
        .clk_d(clk_d), .reset(reset), .bus(b2.slave));
    sliding_puzzle_ctrl #(.ROWS(3), .COLS(3), .TW(4), .BLANK(9), .MCW(2)) dut3 (
        .clk_d(clk_d), .reset(reset), .bus(b3.slave));

    // Reference model of the 2x2 instance (blank code 4).
    int m_board[4];
    int m_shadow[4];
    int m_bp;
    int m_cnt;
    bit m_err, m_win, m_ill;

    task automatic step();
        @(posedge clk_d);
        #1;
    endtask

    task automatic load2(input logic [11:0] board);
        b2.game_status = 2'b00; b2.origin_board = board; step();
        b2.game_status = 2'b10; step(); step();
        b2.game_status = 2'b01;
    endtask

    task automatic load3(input logic [35:0] board);
        b3.game_status = 2'b00; b3.origin_board = board; step();
        b3.game_status = 2'b10; step(); step();
        b3.game_status = 2'b01;
    endtask

    task automatic strobe2(input logic [3:0] a);
        b2.active = 1'b1; b2.act = a; step();
        b2.active = 1'b0; b2.act = 4'b0000;
    endtask

    task automatic test_reset();
        reset = 1'b0; b2.active = 1'b1; b2.act = 4'b0010; step();
        n_tests++; if (b2.out !== 12'h924) begin n_fail++; $display("FAIL reset_out: got %h want %h", b2.out, 12'h924); end
        n_tests++; if (b2.blank_pos !== 2'd2) begin n_fail++; $display("FAIL reset_blank: got %0d want 2", b2.blank_pos); end
        n_tests++; if (b2.move_cnt !== 10'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", b2.move_cnt); end
        n_tests++; if ({b2.illegal, b2.board_err, b2.win_flag} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {b2.illegal, b2.board_err, b2.win_flag}); end
        n_tests++; if (b3.out !== 36'h999999999) begin n_fail++; $display("FAIL reset3_out: got %h want %h", b3.out, 36'h999999999); end
        n_tests++; if (b3.blank_pos !== 4'd6) begin n_fail++; $display("FAIL reset3_blank: got %0d want 6", b3.blank_pos); end
        b2.active = 1'b0; b2.act = 4'b0000; reset = 1'b1;
    endtask

    task automatic test_solve();
        load2(12'b000_001_100_010);
        n_tests++; if (b2.blank_pos !== 2'd2) begin n_fail++; $display("FAIL solve_load_blank: got %0d want 2", b2.blank_pos); end
        n_tests++; if (b2.out !== 12'b000_001_100_010) begin n_fail++; $display("FAIL solve_load_out: got %b want 000001100010", b2.out); end
        strobe2(4'b0010);
        n_tests++; if (b2.out !== 12'b000_001_010_100) begin n_fail++; $display("FAIL solve_out: got %b want 000001010100", b2.out); end
        n_tests++; if (b2.blank_pos !== 2'd3) begin n_fail++; $display("FAIL solve_blank: got %0d want 3", b2.blank_pos); end
        n_tests++; if (b2.move_cnt !== 10'd1) begin n_fail++; $display("FAIL solve_cnt: got %0d want 1", b2.move_cnt); end
        n_tests++; if (b2.win_flag !== 1'b0) begin n_fail++; $display("FAIL solve_win_early: got %b want 0", b2.win_flag); end
        step();
        n_tests++; if (b2.win_flag !== 1'b1) begin n_fail++; $display("FAIL solve_win: got %b want 1", b2.win_flag); end
        strobe2(4'b1000);
        n_tests++; if (b2.out !== 12'b000_001_010_100) begin n_fail++; $display("FAIL solve_after_out: got %b want 000001010100", b2.out); end
        n_tests++; if ({b2.illegal, b2.move_cnt} !== {1'b0, 10'd1}) begin n_fail++; $display("FAIL solve_after_ill_cnt: got %b/%0d want 0/1", b2.illegal, b2.move_cnt); end
        b2.game_status = 2'b11; step();
        n_tests++; if ({b2.out, b2.win_flag} !== {12'b000_001_010_100, 1'b1}) begin n_fail++; $display("FAIL winned_hold: got %b/%b want 000001010100/1", b2.out, b2.win_flag); end
    endtask

    task automatic test_edge();
        load2(12'b000_001_100_010);
        strobe2(4'b1000);
        n_tests++; if (b2.illegal !== 1'b1) begin n_fail++; $display("FAIL edge_left_ill: got %b want 1", b2.illegal); end
        n_tests++; if ({b2.out, b2.blank_pos, b2.move_cnt} !== {12'b000_001_100_010, 2'd2, 10'd0}) begin n_fail++; $display("FAIL edge_left_hold: got %b/%0d/%0d want 000001100010/2/0", b2.out, b2.blank_pos, b2.move_cnt); end
        step();
        n_tests++; if (b2.illegal !== 1'b0) begin n_fail++; $display("FAIL edge_left_pulse: got %b want 0", b2.illegal); end
        strobe2(4'b0100);
        n_tests++; if (b2.illegal !== 1'b1) begin n_fail++; $display("FAIL edge_down_ill: got %b want 1", b2.illegal); end
        n_tests++; if ({b2.out, b2.blank_pos, b2.move_cnt} !== {12'b000_001_100_010, 2'd2, 10'd0}) begin n_fail++; $display("FAIL edge_down_hold: got %b/%0d/%0d want 000001100010/2/0", b2.out, b2.blank_pos, b2.move_cnt); end
        step();
        n_tests++; if (b2.illegal !== 1'b0) begin n_fail++; $display("FAIL edge_down_pulse: got %b want 0", b2.illegal); end
    endtask

    task automatic test_priority();
        load2(12'b000_001_100_010);
        strobe2(4'b0011);
        n_tests++; if (b2.out !== 12'b100_001_000_010) begin n_fail++; $display("FAIL prio_out: got %b want 100001000010", b2.out); end
        n_tests++; if ({b2.blank_pos, b2.move_cnt} !== {2'd0, 10'd1}) begin n_fail++; $display("FAIL prio_blank_cnt: got %0d/%0d want 0/1", b2.blank_pos, b2.move_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq[3] = '{4'b0001, 4'b0010, 4'b0100};
        load2(12'b000_001_100_010);
        b2.active = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b2.act = seq[i]; step();
        end
        b2.active = 1'b0; b2.act = 4'b0000;
        n_tests++; if (b2.out !== 12'b001_010_000_100) begin n_fail++; $display("FAIL b2b_out: got %b want 001010000100", b2.out); end
        n_tests++; if ({b2.blank_pos, b2.move_cnt} !== {2'd3, 10'd3}) begin n_fail++; $display("FAIL b2b_blank_cnt: got %0d/%0d want 3/3", b2.blank_pos, b2.move_cnt); end
        b2.restart = 1'b1; b2.active = 1'b1; b2.act = 4'b0001; step();
        b2.restart = 1'b0; b2.active = 1'b0; b2.act = 4'b0000;
        n_tests++; if (b2.out !== 12'b000_001_100_010) begin n_fail++; $display("FAIL restart_out: got %b want 000001100010", b2.out); end
        n_tests++; if ({b2.blank_pos, b2.move_cnt} !== {2'd2, 10'd0}) begin n_fail++; $display("FAIL restart_blank_cnt: got %0d/%0d want 2/0", b2.blank_pos, b2.move_cnt); end
    endtask

    task automatic test_reset_mid();
        load2(12'b000_001_100_010);
        b2.active = 1'b1; b2.act = 4'b0010; reset = 1'b0; step();
        n_tests++; if (b2.out !== 12'h924) begin n_fail++; $display("FAIL midreset_out: got %h want 924", b2.out); end
        n_tests++; if ({b2.blank_pos, b2.move_cnt} !== {2'd2, 10'd0}) begin n_fail++; $display("FAIL midreset_blank_cnt: got %0d/%0d want 2/0", b2.blank_pos, b2.move_cnt); end
        n_tests++; if ({b2.illegal, b2.board_err, b2.win_flag} !== 3'b000) begin n_fail++; $display("FAIL midreset_flags: got %b want 000", {b2.illegal, b2.board_err, b2.win_flag}); end
        reset = 1'b1; b2.active = 1'b0; b2.act = 4'b0000; step();
        n_tests++; if (b2.win_flag !== 1'b0) begin n_fail++; $display("FAIL allblank_win: got %b want 0", b2.win_flag); end
    endtask

    task automatic test_noblank();
        load2(12'b000_001_010_011);
        n_tests++; if ({b2.board_err, b2.blank_pos} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL noblank_err_blank: got %b/%0d want 1/2", b2.board_err, b2.blank_pos); end
        strobe2(4'b0010);
        n_tests++; if ({b2.illegal, b2.out, b2.move_cnt} !== {1'b0, 12'b000_001_010_011, 10'd0}) begin n_fail++; $display("FAIL noblank_move: got %b/%b/%0d want 0/000001010011/0", b2.illegal, b2.out, b2.move_cnt); end
        strobe2(4'b1000);
        n_tests++; if (b2.illegal !== 1'b0) begin n_fail++; $display("FAIL noblank_ill: got %b want 0", b2.illegal); end
        load2(12'b000_001_100_010);
        n_tests++; if (b2.board_err !== 1'b0) begin n_fail++; $display("FAIL noblank_clear: got %b want 0", b2.board_err); end
    endtask

    task automatic test_3x3();
        logic [3:0] acts[6]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b0100};
        int         exp_bp[6]  = '{5, 8, 7, 4, 7, 7};
        int         exp_cnt[6] = '{1, 2, 3, 3, 3, 3};
        logic       exp_ill[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        load3(36'h102395678);
        n_tests++; if ({b3.blank_pos, b3.board_err} !== {4'd4, 1'b0}) begin n_fail++; $display("FAIL 3x3_load: got %0d/%b want 4/0", b3.blank_pos, b3.board_err); end
        for (int i = 0; i < 6; i++) begin
            b3.active = 1'b1; b3.act = acts[i]; step();
            b3.active = 1'b0; b3.act = 4'b0000;
            n_tests++;
            if (b3.blank_pos !== 4'(exp_bp[i]) || b3.move_cnt !== 2'(exp_cnt[i]) || b3.illegal !== exp_ill[i]) begin
                n_fail++;
                $display("FAIL 3x3_move[%0d]: got blank %0d cnt %0d ill %b want blank %0d cnt %0d ill %b",
                         i, b3.blank_pos, b3.move_cnt, b3.illegal, exp_bp[i], exp_cnt[i], exp_ill[i]);
            end
        end
        n_tests++; if (b3.out !== 36'h102358697) begin n_fail++; $display("FAIL 3x3_out: got %h want 102358697", b3.out); end
    endtask

    function automatic bit model_solved();
        int blanks = 0;
        bit ok     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (m_board[k] == 4) blanks++;
            else if (m_board[k] != k) ok = 1'b0;
        end
        return ok && (blanks == 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin m_board[k] = 4; m_shadow[k] = 0; end
        m_bp = 2; m_cnt = 0; m_err = 0; m_win = 0; m_ill = 0;
    endtask

    task automatic model_load();
        m_board = m_shadow;
        m_cnt   = 0;
        m_bp    = -1;
        for (int k = 3; k >= 0; k--) if (m_shadow[k] == 4) m_bp = k;
        m_err = (m_bp < 0);
        if (m_bp < 0) m_bp = 2;
    endtask

    // One clock edge of the spec: win is judged on the pre-edge board, moves use pre-edge flags.
    task automatic model_edge(input logic [1:0] st, input logic [3:0] a, input bit act_v, input bit rs, input int org[4]);
        bit win_now = model_solved();
        bit gate    = act_v && !m_err && !m_win && (a != 4'b0000);
        int dr = 0, dc = 0, r, c, t;
        m_ill = 1'b0;
        if (st == 2'b00) m_shadow = org;
        else if (st == 2'b10 || (st == 2'b01 && rs)) model_load();
        else if (st == 2'b01 && gate) begin
            if (a[0]) dr = -1; else if (a[1]) dc = 1; else if (a[2]) dr = 1; else dc = -1;
            r = m_bp / 2 + dr;
            c = m_bp % 2 + dc;
            if (r >= 0 && r < 2 && c >= 0 && c < 2) begin
                t = m_board[r*2+c]; m_board[r*2+c] = m_board[m_bp]; m_board[m_bp] = t;
                m_bp = r*2 + c;
                if (m_cnt < 1023) m_cnt++;
            end else begin
                m_ill = 1'b1;
            end
        end
        m_win = win_now;
    endtask

    task automatic test_random();
        int org[4];
        int rv, j, t;
        logic [1:0]  st;
        logic [3:0]  a;
        bit          act_v, rs, rst_low;
        logic [11:0] exp_out, org_vec;
        reset = 1'b0; step(); reset = 1'b1;
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rv = $urandom_range(0, 99);
            st = (rv < 70) ? 2'b01 : (rv < 80) ? 2'b00 : (rv < 90) ? 2'b10 : 2'b11;
            a       = 4'($urandom_range(0, 15));
            act_v   = 1'($urandom_range(0, 1));
            rs      = ($urandom_range(0, 19) == 0);
            rst_low = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) != 0) begin
                for (int k = 0; k < 4; k++) org[k] = k;
                for (int k = 3; k > 0; k--) begin
                    j = $urandom_range(0, k); t = org[k]; org[k] = org[j]; org[j] = t;
                end
                org[$urandom_range(0, 3)] = 4;
            end else begin
                for (int k = 0; k < 4; k++) org[k] = $urandom_range(0, 7);
            end
            for (int k = 0; k < 4; k++) org_vec[(3-k)*3 +: 3] = 3'(org[k]);
            b2.game_status = st; b2.act = a; b2.active = act_v; b2.restart = rs;
            b2.origin_board = org_vec; reset = !rst_low;
            if (rst_low) model_reset();
            else model_edge(st, a, act_v, rs, org);
            step();
            for (int k = 0; k < 4; k++) exp_out[(3-k)*3 +: 3] = 3'(m_board[k]);
            n_tests++; if (b2.out !== exp_out) begin n_fail++; $display("FAIL rand_out[%0d]: got %b want %b", cyc, b2.out, exp_out); end
            n_tests++; if (b2.blank_pos !== 2'(m_bp)) begin n_fail++; $display("FAIL rand_blank[%0d]: got %0d want %0d", cyc, b2.blank_pos, m_bp); end
            n_tests++; if (b2.move_cnt !== 10'(m_cnt)) begin n_fail++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", cyc, b2.move_cnt, m_cnt); end
            n_tests++; if ({b2.illegal, b2.board_err, b2.win_flag} !== {m_ill, m_err, m_win}) begin n_fail++; $display("FAIL rand_flags[%0d]: got %b want %b", cyc, {b2.illegal, b2.board_err, b2.win_flag}, {m_ill, m_err, m_win}); end
        end
        reset = 1'b1; b2.active = 1'b0; b2.act = 4'b0000; b2.restart = 1'b0;
    endtask

    // Hard stop if the sequence ever stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        b2.game_status = 2'b00; b2.act = 4'b0000; b2.active = 1'b0; b2.restart = 1'b0; b2.origin_board = '0;
        b3.game_status = 2'b00; b3.act = 4'b0000; b3.active = 1'b0; b3.restart = 1'b0; b3.origin_board = '0;
        step();
        test_reset();
        test_solve();
        test_edge();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        test_noblank();
        test_3x3();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
